lane_move_ctrl: RTL and testbench
=================================

Name: lane_move_ctrl

Overview:
- Sequences the player character's lateral motion for the runner game.
- Converts the 10-bit accelerometer tilt value into discrete three-lane changes: debounce, animated step-per-frame motion, cooldown, then mandatory return to neutral.
- Sits between the accelerometer front end and the sprite renderer/collision logic, which consume char_x/char_y/lane.

Parameters:
- LANE0_X, 140, x pixel of left lane
- LANE1_X, 260, x pixel of centre lane (reset position)
- LANE2_X, 380, x pixel of right lane
- Y, 350, fixed character y pixel
- LEFT_MAX, 212, acl_in <= this is a left tilt
- RIGHT_MIN, 416, lower bound of right tilt
- RIGHT_MAX, 469, upper bound of right tilt
- STEP, 20, pixels moved per tick during a lane change (must be >= 1)
- HOLD, 3, consecutive ticks a tilt must persist before a move (must be >= 1)
- COOLDOWN, 8, ticks after arrival during which tilt is ignored

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- win_rst  in  1  synchronous reset on game restart, same effect as rst
- tick  in  1  one-cycle frame strobe; all timing counts ticks
- acl_in  in  10  accelerometer tilt value
- char_x  out  10  character x pixel
- char_y  out  9  character y pixel, constant Y
- lane  out  2  current lane: 0, 1 or 2; 3 never driven
- moving  out  1  high while in MOVE
- busy  out  1  high in any state other than IDLE
- lane_changed  out  1  one-cycle pulse on arrival at the target lane

Behaviour:
- Reset (rst async, or win_rst sync with priority over all other logic): char_x=LANE1_X, lane=1, state IDLE, counters 0, moving=0, busy=0, lane_changed=0. char_y is always Y.
- Tilt classification, combinational:
  - LEFT if acl_in <= LEFT_MAX.
  - RIGHT if RIGHT_MIN <= acl_in <= RIGHT_MAX.
  - NEUTRAL otherwise, including acl_in > RIGHT_MAX.
- A direction is "allowed" if it is LEFT with lane > 0, or RIGHT with lane < 2. Blocked directions count as NEUTRAL for qualification.
- acl_in is evaluated only on cycles with tick=1. All state changes except resets occur only on tick cycles.
- IDLE:
  - On tick with an allowed direction: latch dir, set cnt=1.
  - If HOLD==1, compute target and go to MOVE. Otherwise go to QUAL.
- QUAL:
  - On tick with the same latched direction: cnt++. When cnt==HOLD, set target lane = lane−1 (LEFT) or lane+1 (RIGHT), target_x from the lane table, then go to MOVE.
  - On tick with any other direction: go to IDLE, cnt=0.
- MOVE (moving=1), on each tick:
  - If |target_x − char_x| <= STEP: set char_x=target_x, lane=target lane, pulse lane_changed for that cycle, cnt=0, go to COOL.
  - Otherwise move char_x by STEP toward target_x.
  - Use unsigned 10-bit arithmetic. Compute the difference before subtracting so char_x never underflows or overshoots.
  - acl_in is ignored in MOVE.
- COOL: count ticks. When COOLDOWN ticks have elapsed, go to WAIT_NEUTRAL. If COOLDOWN==0, go to WAIT_NEUTRAL on the next tick. acl_in is ignored.
- WAIT_NEUTRAL: on tick with a raw NEUTRAL classification (not blocked-as-neutral), go to IDLE. A held tilt therefore produces exactly one lane change.
- lane only updates at arrival. During MOVE, lane holds the source lane.
- Reset mid-operation: any state returns to the reset values. No partial move persists.
- Latency: the first qualifying tick is tick 0. MOVE is entered at tick HOLD−1. The first pixel step occurs at tick HOLD. Arrival takes ceil(lane spacing / STEP) ticks.

Test Plan:
1. Reset check: assert rst asynchronously mid-cycle → char_x=260, lane=1, char_y=350, busy=0 immediately without a clock edge.
2. Hold acl_in=100 for 3 ticks → MOVE. char_x steps 240, 220, 200, 180, 160, 140 over 6 ticks. Then lane=0 with a single lane_changed pulse. busy stays high through 8 COOL ticks. Set acl_in=300 → IDLE.
3. From lane 1, hold acl_in=440 continuously for 30 ticks → exactly one move to char_x=380, lane=2; no second move. Then acl_in=300 then 100 held for 3 ticks → returns to 260.
4. Glitch rejection: acl_in=450 for 2 ticks then 300 → no move, state back to IDLE. acl_in=500 held for 10 ticks → treated as neutral, no move.
5. Edge lane: at lane 0 hold acl_in=50 for 10 ticks → stays IDLE, busy=0, char_x=140. Tilt during COOL (acl_in=440) → ignored.
6. win_rst pulse while in MOVE at char_x=320 → next edge char_x=260, lane=1, moving=0, IDLE. A subsequent 3-tick tilt moves normally.

Source files
------------

// File: rtl/lane_move_ctrl.sv
// lane_move_ctrl: tilt-driven three-lane character motion sequencer.
// Debounce, per-frame stepping, cooldown, then wait for neutral tilt.
module lane_move_ctrl #(
  parameter int LANE0_X   = 140,
  parameter int LANE1_X   = 260,
  parameter int LANE2_X   = 380,
  parameter int Y         = 350,
  parameter int LEFT_MAX  = 212,
  parameter int RIGHT_MIN = 416,
  parameter int RIGHT_MAX = 469,
  parameter int STEP      = 20,
  parameter int HOLD      = 3,
  parameter int COOLDOWN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win_rst,
  input  logic       tick,
  input  logic [9:0] acl_in,
  output logic [9:0] char_x,
  output logic [8:0] char_y,
  output logic [1:0] lane,
  output logic       moving,
  output logic       busy,
  output logic       lane_changed
);

  typedef enum logic [2:0] {
    IDLE, QUAL, MOVE, COOL, WAIT_N
  } state_t;

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       dir, dir_d;
  logic [1:0] lane_d, tl, tl_d;
  logic [9:0] x_d, tx, tx_d;
  logic       chg_d;
  logic       is_l, is_r, is_n;
  logic       ok_l, ok_r;
  logic [9:0] diff;

  function automatic logic [1:0] nxt_lane(
    input logic [1:0] l, input logic d);
    return d ? l + 2'd1 : l - 2'd1;
  endfunction

  function automatic logic [9:0] lane_x(input logic [1:0] l);
    case (l)
      2'd0:    return 10'(LANE0_X);
      2'd2:    return 10'(LANE2_X);
      default: return 10'(LANE1_X);
    endcase
  endfunction

  // Raw tilt classification; blocked directions only count as neutral
  // for qualification, not for leaving WAIT_N.
  assign is_l = acl_in <= 10'(LEFT_MAX);
  assign is_r = (acl_in >= 10'(RIGHT_MIN)) && (acl_in <= 10'(RIGHT_MAX));
  assign is_n = !is_l && !is_r;
  assign ok_l = is_l && (lane != 2'd0);
  assign ok_r = is_r && (lane != 2'd2);

  // Distance computed before subtracting so char_x cannot wrap.
  assign diff = (tx >= char_x) ? tx - char_x : char_x - tx;

  assign char_y = 9'(Y);
  assign moving = state == MOVE;
  assign busy   = state != IDLE;

  // Next-state and datapath updates, all gated by the frame tick.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dir_d   = dir;
    lane_d  = lane;
    x_d     = char_x;
    tl_d    = tl;
    tx_d    = tx;
    chg_d   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (ok_l || ok_r) begin
            dir_d = ok_r;
            cnt_d = 8'd1;
            if (HOLD == 1) begin
              tl_d    = nxt_lane(lane, ok_r);
              tx_d    = lane_x(tl_d);
              state_d = MOVE;
            end else begin
              state_d = QUAL;
            end
          end
        end
        QUAL: begin
          if (dir ? ok_r : ok_l) begin
            cnt_d = cnt + 8'd1;
            if (cnt_d == 8'(HOLD)) begin
              tl_d    = nxt_lane(lane, dir);
              tx_d    = lane_x(tl_d);
              state_d = MOVE;
            end
          end else begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end
        end
        MOVE: begin
          if (diff <= 10'(STEP)) begin
            x_d     = tx;
            lane_d  = tl;
            chg_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = COOL;
          end else if (tx > char_x) begin
            x_d = char_x + 10'(STEP);
          end else begin
            x_d = char_x - 10'(STEP);
          end
        end
        COOL: begin
          if (COOLDOWN == 0 || (cnt + 8'd1) >= 8'(COOLDOWN)) begin
            cnt_d   = 8'd0;
            state_d = WAIT_N;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
        WAIT_N: begin
          if (is_n) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; game restart behaves exactly like power-on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      dir          <= 1'b0;
      lane         <= 2'd1;
      char_x       <= 10'(LANE1_X);
      tl           <= 2'd1;
      tx           <= 10'(LANE1_X);
      lane_changed <= 1'b0;
    end else if (win_rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      dir          <= 1'b0;
      lane         <= 2'd1;
      char_x       <= 10'(LANE1_X);
      tl           <= 2'd1;
      tx           <= 10'(LANE1_X);
      lane_changed <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      dir          <= dir_d;
      lane         <= lane_d;
      char_x       <= x_d;
      tl           <= tl_d;
      tx           <= tx_d;
      lane_changed <= chg_d;
    end
  end

endmodule

// File: tb/tb_lane_move_ctrl.sv
// tb_lane_move_ctrl: directed scenario bench for lane_move_ctrl.
// Tick strobes are spaced one idle cycle apart.
module tb_lane_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       win_rst = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] acl_in = 10'd300;
  logic [9:0] char_x;
  logic [8:0] char_y;
  logic [1:0] lane;
  logic       moving;
  logic       busy;
  logic       lane_changed;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  lane_move_ctrl dut (
    .clk(clk), .rst(rst), .win_rst(win_rst), .tick(tick),
    .acl_in(acl_in), .char_x(char_x), .char_y(char_y),
    .lane(lane), .moving(moving), .busy(busy),
    .lane_changed(lane_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (lane_changed === 1'b1) pulses++;

  task automatic tk(input int a);
    @(negedge clk);
    acl_in = 10'(a);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (char_x !== 10'd260 || lane !== 2'd1 || char_y !== 9'd350
        || busy !== 1'b0 || moving !== 1'b0 || lane_changed !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: x=%0d lane=%0d y=%0d busy=%b mv=%b lc=%b want 260/1/350/0/0/0",
               char_x, lane, char_y, busy, moving, lane_changed);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_left_move;
    int xs[6] = '{240, 220, 200, 180, 160, 140};
    int p0;
    p0 = pulses;
    repeat (3) tk(100);
    n_cmp++;
    if (moving !== 1'b1 || char_x !== 10'd260) begin
      n_bad++;
      $display("FAIL left_enter_move: mv=%b x=%0d want 1/260", moving, char_x);
    end
    for (int i = 0; i < 6; i++) begin
      tk(100);
      n_cmp++;
      if (char_x !== 10'(xs[i])) begin
        n_bad++;
        $display("FAIL left_step%0d: x=%0d want %0d", i, char_x, xs[i]);
      end
      if (i == 4) begin
        n_cmp++;
        if (lane !== 2'd1 || moving !== 1'b1) begin
          n_bad++;
          $display("FAIL left_src_lane: lane=%0d mv=%b want 1/1", lane, moving);
        end
      end
    end
    n_cmp++;
    if (lane !== 2'd0 || moving !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL left_arrive: lane=%0d mv=%b busy=%b want 0/0/1", lane, moving, busy);
    end
    repeat (8) tk(300);
    n_cmp++;
    if (busy !== 1'b1 || pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL left_cool: busy=%b pulses=%0d want 1/1", busy, pulses - p0);
    end
    tk(300);
    n_cmp++;
    if (busy !== 1'b0 || char_x !== 10'd140) begin
      n_bad++;
      $display("FAIL left_idle: busy=%b x=%0d want 0/140", busy, char_x);
    end
  endtask

  task automatic test_edge_lane;
    repeat (10) tk(50);
    n_cmp++;
    if (busy !== 1'b0 || char_x !== 10'd140 || lane !== 2'd0) begin
      n_bad++;
      $display("FAIL edge_blocked: busy=%b x=%0d lane=%0d want 0/140/0", busy, char_x, lane);
    end
    repeat (9) tk(440);
    n_cmp++;
    if (char_x !== 10'd260 || lane !== 2'd1) begin
      n_bad++;
      $display("FAIL edge_to_centre: x=%0d lane=%0d want 260/1", char_x, lane);
    end
    repeat (8) tk(440);
    n_cmp++;
    if (char_x !== 10'd260 || lane !== 2'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL edge_cool_ignore: x=%0d lane=%0d busy=%b want 260/1/1", char_x, lane, busy);
    end
    tk(300);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL edge_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_held_right;
    int p0;
    p0 = pulses;
    repeat (30) tk(440);
    n_cmp++;
    if (char_x !== 10'd380 || lane !== 2'd2 || busy !== 1'b1
        || pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL held_right: x=%0d lane=%0d busy=%b pulses=%0d want 380/2/1/1",
               char_x, lane, busy, pulses - p0);
    end
    tk(300);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_right_idle: busy=%b want 0", busy);
    end
    repeat (9) tk(100);
    n_cmp++;
    if (char_x !== 10'd260 || lane !== 2'd1) begin
      n_bad++;
      $display("FAIL held_return: x=%0d lane=%0d want 260/1", char_x, lane);
    end
    repeat (8) tk(300);
    tk(300);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_return_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_glitch;
    tk(450);
    tk(450);
    tk(300);
    n_cmp++;
    if (busy !== 1'b0 || char_x !== 10'd260) begin
      n_bad++;
      $display("FAIL glitch: busy=%b x=%0d want 0/260", busy, char_x);
    end
    repeat (10) tk(500);
    n_cmp++;
    if (busy !== 1'b0 || char_x !== 10'd260) begin
      n_bad++;
      $display("FAIL over_range: busy=%b x=%0d want 0/260", busy, char_x);
    end
  endtask

  task automatic test_bounds;
    int v[8] = '{213, 470, 415, 416, 469, 300, 212, 300};
    logic b[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tk(v[i]);
      n_cmp++;
      if (busy !== b[i]) begin
        n_bad++;
        $display("FAIL bound_%0d: busy=%b want %b", v[i], busy, b[i]);
      end
    end
  endtask

  task automatic test_win_rst;
    repeat (6) tk(440);
    n_cmp++;
    if (char_x !== 10'd320 || moving !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_pre: x=%0d mv=%b want 320/1", char_x, moving);
    end
    @(negedge clk);
    win_rst = 1'b1;
    @(negedge clk);
    win_rst = 1'b0;
    n_cmp++;
    if (char_x !== 10'd260 || lane !== 2'd1 || moving !== 1'b0
        || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_post: x=%0d lane=%0d mv=%b busy=%b want 260/1/0/0",
               char_x, lane, moving, busy);
    end
    repeat (3) tk(100);
    n_cmp++;
    if (moving !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_retilt: mv=%b want 1", moving);
    end
    repeat (6) tk(100);
    n_cmp++;
    if (char_x !== 10'd140 || lane !== 2'd0) begin
      n_bad++;
      $display("FAIL wr_move: x=%0d lane=%0d want 140/0", char_x, lane);
    end
  endtask

  initial begin
    test_reset();
    test_left_move();
    test_edge_lane();
    test_held_right();
    test_glitch();
    test_bounds();
    test_win_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
